// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector.
// Matches a LEN-bit PATTERN (MSB received first) on the serial input x, qualified by en.
// Overlapping or non-overlapping matching is selected at run time by overlap.
// A registered one-cycle pulse on y marks each match, and a saturating counter tracks matches.
module seq_detector_param #(
    parameter int unsigned    LEN     = 4,
    parameter logic [LEN-1:0] PATTERN = 4'b1011,
    parameter int unsigned    CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             x,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             y,
    output logic [CNT_W-1:0] cnt
);

    // fill counts 0..LEN, so it needs enough bits to hold LEN itself.
    localparam int unsigned      FW        = $clog2(LEN + 1);
    localparam logic [FW-1:0]    FILL_FULL = FW'(LEN);
    localparam logic [FW-1:0]    FILL_ARM  = FW'(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Only the newest LEN-1 bits are stored. The oldest bit of a LEN-bit history
    // would be shifted out before anything compared it, so it is never kept.
    logic [LEN-2:0]   hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             y_q;
    logic [LEN-1:0]   cand;
    logic             hit;

    // Build the candidate word from stored history and the current bit, then detect a match.
    always_comb begin
        cand = {hist_q, x};
        hit  = en & (fill_q >= FILL_ARM) & (cand == PATTERN);
    end

    // Next-state logic for history and fill level. Nothing advances while en is low.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (en) begin
            hist_d = cand[LEN-2:0];
            if (hit) begin
                // In non-overlap mode, bits of the matched pattern must not count toward the next match.
                fill_d = overlap ? FILL_FULL : '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end
        end
    end

    // Hit counter. A clear takes priority, but a hit on the same edge still counts after the clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = hit ? CNT_ONE : '0;
        end else if (hit && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // State registers. Reset is asynchronous, so it also clears a pending y pulse immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            y_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            y_q    <= hit;
        end
    end

    assign y   = y_q;
    assign cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param.
// It instantiates three configurations: the default 1011 detector, a LEN=3 detector for 111,
// and a detector with a 2-bit counter.
// Vector tables hold the expected y and cnt for each edge. Expectations go into a scoreboard
// queue when a vector is driven, and are popped and compared after the clock edge.
module tb_seq_detector_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic en0, x0, ov0, clr0, y0;
    logic en1, x1, ov1, clr1, y1;
    logic en2, x2, ov2, clr2, y2;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    seq_detector_param u_dut_def (
        .clk(clk), .rst(rst), .en(en0), .x(x0), .overlap(ov0), .clr_cnt(clr0),
        .y(y0), .cnt(cnt0)
    );

    seq_detector_param #(.LEN(3), .PATTERN(3'b111), .CNT_W(8)) u_dut_111 (
        .clk(clk), .rst(rst), .en(en1), .x(x1), .overlap(ov1), .clr_cnt(clr1),
        .y(y1), .cnt(cnt1)
    );

    seq_detector_param #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .en(en2), .x(x2), .overlap(ov2), .clr_cnt(clr2),
        .y(y2), .cnt(cnt2)
    );

    typedef struct {
        int    dut;
        logic  rst_first;
        logic  en;
        logic  x;
        logic  ov;
        logic  clr;
        logic  ey;
        int    ecnt;
        string name;
    } vec_t;

    typedef struct {
        logic  y;
        int    cnt;
        string name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(int d, int r, int e, int xx, int o, int c, int ey, int ec,
                                string nm);
        vec_t v;
        v.dut       = d;
        v.rst_first = (r != 0);
        v.en        = (e != 0);
        v.x         = (xx != 0);
        v.ov        = (o != 0);
        v.clr       = (c != 0);
        v.ey        = (ey != 0);
        v.ecnt      = ec;
        v.name      = nm;
        vecs.push_back(v);
    endfunction

    function automatic logic get_y(int d);
        case (d)
            0:       return y0;
            1:       return y1;
            default: return y2;
        endcase
    endfunction

    function automatic int get_cnt(int d);
        case (d)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    task automatic check(string nm, logic ay, logic ey, int acnt, int ecnt);
        checks++;
        if (ay !== ey || acnt != ecnt) begin
            failures++;
            $display("FAIL %s: got y=%0b cnt=%0d, expected y=%0b cnt=%0d", nm, ay, acnt, ey, ecnt);
        end
    endtask

    task automatic drive(int d, logic e, logic xx, logic o, logic c);
        {en0, x0, ov0, clr0} = 4'b0000;
        {en1, x1, ov1, clr1} = 4'b0000;
        {en2, x2, ov2, clr2} = 4'b0000;
        case (d)
            0:       {en0, x0, ov0, clr0} = {e, xx, o, c};
            1:       {en1, x1, ov1, clr1} = {e, xx, o, c};
            default: {en2, x2, ov2, clr2} = {e, xx, o, c};
        endcase
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_all();
        exp_t e;
        foreach (vecs[i]) begin
            if (vecs[i].rst_first) do_reset();
            drive(vecs[i].dut, vecs[i].en, vecs[i].x, vecs[i].ov, vecs[i].clr);
            e.y    = vecs[i].ey;
            e.cnt  = vecs[i].ecnt;
            e.name = vecs[i].name;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check(e.name, get_y(vecs[i].dut), e.y, get_cnt(vecs[i].dut), e.cnt);
        end
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        for (int d = 0; d < 3; d++) check($sformatf("reset_dut%0d", d), get_y(d), 1'b0, get_cnt(d), 0);
        rst = 1'b0;

        // Table: dut, rst_first, en, x, overlap, clr_cnt, exp y, exp cnt, name
        // T1: default detector, non-overlapping matches
        add(0, 1, 1, 1, 0, 0, 0, 0, "t1_b1");
        add(0, 0, 1, 0, 0, 0, 0, 0, "t1_b2");
        add(0, 0, 1, 1, 0, 0, 0, 0, "t1_b3");
        add(0, 0, 1, 1, 0, 0, 1, 1, "t1_b4_hit");
        add(0, 0, 1, 0, 0, 0, 0, 1, "t1_b5");
        add(0, 0, 1, 1, 0, 0, 0, 1, "t1_b6");
        add(0, 0, 1, 1, 0, 0, 0, 1, "t1_b7_nohit");
        // T2: same stream, overlapping matches
        add(0, 1, 1, 1, 1, 0, 0, 0, "t2_b1");
        add(0, 0, 1, 0, 1, 0, 0, 0, "t2_b2");
        add(0, 0, 1, 1, 1, 0, 0, 0, "t2_b3");
        add(0, 0, 1, 1, 1, 0, 1, 1, "t2_b4_hit");
        add(0, 0, 1, 0, 1, 0, 0, 1, "t2_b5");
        add(0, 0, 1, 1, 1, 0, 0, 1, "t2_b6");
        add(0, 0, 1, 1, 1, 0, 1, 2, "t2_b7_hit");
        // T3: en gaps leave state frozen and hold y low
        add(0, 1, 1, 1, 0, 0, 0, 0, "t3_b1");
        add(0, 0, 1, 0, 0, 0, 0, 0, "t3_b2");
        add(0, 0, 0, 1, 0, 0, 0, 0, "t3_gap1");
        add(0, 0, 0, 1, 0, 0, 0, 0, "t3_gap2");
        add(0, 0, 0, 1, 0, 0, 0, 0, "t3_gap3");
        add(0, 0, 1, 1, 0, 0, 0, 0, "t3_b3");
        add(0, 0, 1, 1, 0, 0, 1, 1, "t3_b4_hit");
        // T3b: the final pattern bit with en=0 is ignored, and en=0 drops y
        add(0, 1, 1, 1, 0, 0, 0, 0, "t3b_b1");
        add(0, 0, 1, 0, 0, 0, 0, 0, "t3b_b2");
        add(0, 0, 1, 1, 0, 0, 0, 0, "t3b_b3");
        add(0, 0, 0, 1, 0, 0, 0, 0, "t3b_gated_last");
        add(0, 0, 1, 1, 0, 0, 1, 1, "t3b_hit");
        add(0, 0, 0, 1, 0, 0, 0, 1, "t3b_en0_drops_y");
        // T4: LEN=3 pattern 111
        add(1, 1, 1, 1, 1, 0, 0, 0, "t4o_b1");
        add(1, 0, 1, 1, 1, 0, 0, 0, "t4o_b2");
        add(1, 0, 1, 1, 1, 0, 1, 1, "t4o_b3");
        add(1, 0, 1, 1, 1, 0, 1, 2, "t4o_b4");
        add(1, 0, 1, 1, 1, 0, 1, 3, "t4o_b5");
        add(1, 1, 1, 1, 0, 0, 0, 0, "t4n_b1");
        add(1, 0, 1, 1, 0, 0, 0, 0, "t4n_b2");
        add(1, 0, 1, 1, 0, 0, 1, 1, "t4n_b3");
        add(1, 0, 1, 1, 0, 0, 0, 1, "t4n_b4");
        add(1, 0, 1, 1, 0, 0, 0, 1, "t4n_b5");
        // T4c: overlap only matters at hit edges
        add(1, 1, 1, 1, 1, 0, 0, 0, "t4c_b1");
        add(1, 0, 1, 1, 1, 0, 0, 0, "t4c_b2");
        add(1, 0, 1, 1, 1, 0, 1, 1, "t4c_b3_ov");
        add(1, 0, 1, 1, 0, 0, 1, 2, "t4c_b4_nov");
        add(1, 0, 1, 1, 1, 0, 0, 2, "t4c_b5_refill");
        // T5: partial pattern before an asynchronous reset
        add(0, 1, 1, 1, 0, 0, 0, 0, "t5_b1");
        add(0, 0, 1, 0, 0, 0, 0, 0, "t5_b2");
        add(0, 0, 1, 1, 0, 0, 0, 0, "t5_b3");
        run_all();

        // Reset pulse between edges discards the partial pattern
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        add(0, 0, 1, 1, 0, 0, 0, 0, "t5_after_rst");
        add(0, 0, 1, 1, 0, 0, 0, 0, "t5_p1");
        add(0, 0, 1, 0, 0, 0, 0, 0, "t5_p2");
        add(0, 0, 1, 1, 0, 0, 0, 0, "t5_p3");
        add(0, 0, 1, 1, 0, 0, 1, 1, "t5_p4_hit");
        run_all();

        // Reset while y is high clears y and cnt immediately
        #1 rst = 1'b1;
        #1 check("t5_rst_clears_y", y0, 1'b0, int'(cnt0), 0);
        rst = 1'b0;

        // T6: 2-bit counter saturates over eight 1011 patterns
        for (int i = 0; i < 32; i++) begin
            add(2, (i == 0) ? 1 : 0, 1, ((i % 4) == 1) ? 0 : 1, 1, 0, ((i % 4) == 3) ? 1 : 0,
                ((i + 1) / 4 > 3) ? 3 : (i + 1) / 4, $sformatf("t6_bit%0d", i + 1));
        end
        add(2, 0, 1, 1, 1, 0, 0, 3, "t6_c1");
        add(2, 0, 1, 0, 1, 0, 0, 3, "t6_c2");
        add(2, 0, 1, 1, 1, 0, 0, 3, "t6_c3");
        add(2, 0, 1, 1, 1, 1, 1, 1, "t6_clr_on_hit");
        add(2, 0, 1, 0, 1, 1, 0, 0, "t6_clr_alone");
        run_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
